// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and a small helper for telling signed ops apart.
package mdu_pkg;

   localparam logic [1:0] MDU_MULT  = 2'd0;
   localparam logic [1:0] MDU_MULTU = 2'd1;
   localparam logic [1:0] MDU_DIV   = 2'd2;
   localparam logic [1:0] MDU_DIVU  = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_MUL  = 3'd1,
      ST_DIV  = 3'd2,
      ST_FIX  = 3'd3,
      ST_DONE = 3'd4
   } mdu_state_e;

   function automatic logic op_is_signed(input logic [1:0] op);
      return (op == MDU_MULT) || (op == MDU_DIV);
   endfunction

endpackage

// File: rtl/mdu_divider.sv
// Iterative restoring radix-2 divider on unsigned magnitudes; one quotient
// bit per cycle, WIDTH cycles after the start pulse.
module mdu_divider
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             flush,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             ready
);

   localparam int CNT_W = $clog2(WIDTH);

   logic             running_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] dvs_q;

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] rem_next;
   logic             q_bit;

   // Partial remainder stays below the divisor, so one extra bit covers the shift.
   always_comb begin
      shifted  = {rem_q, quo_q[WIDTH-1]};
      diff     = shifted - {1'b0, dvs_q};
      rem_next = shifted[WIDTH-1:0];
      q_bit    = 1'b0;
      if (!diff[WIDTH]) begin
         rem_next = diff[WIDTH-1:0];
         q_bit    = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         running_q <= 1'b0;
         cnt_q     <= '0;
         quo_q     <= '0;
         rem_q     <= '0;
         dvs_q     <= '0;
      end else if (flush) begin
         running_q <= 1'b0;
         cnt_q     <= '0;
      end else if (start) begin
         running_q <= 1'b1;
         cnt_q     <= '0;
         quo_q     <= dividend;
         rem_q     <= '0;
         dvs_q     <= divisor;
      end else if (running_q) begin
         quo_q <= {quo_q[WIDTH-2:0], q_bit};
         rem_q <= rem_next;
         cnt_q <= cnt_q + CNT_W'(1);
         if (ready) begin
            running_q <= 1'b0;
         end
      end
   end

   // High during the final iteration; quotient/remainder are final after this edge.
   assign ready     = running_q && (cnt_q == CNT_W'(WIDTH - 1));
   assign quotient  = quo_q;
   assign remainder = rem_q;

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with start/busy/done handshake and flush.
// Define MDU_DIV_EN to build the divider; otherwise divides complete with zeros.
module mul_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int MUL_LAT = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_zero
);

   localparam int CW = $clog2(MUL_LAT + 1);

   mdu_state_e         state_q, state_d;
   logic [CW-1:0]      cnt_q;
   logic               busy_q, done_q, dz_q;
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic               is_div_q, neg_q;
   logic [WIDTH-1:0]   mag_a_q, mag_b_q;
   logic [WIDTH-1:0]   res_hi_q, res_lo_q;
   logic               res_dz_q;

   logic               accept, signed_in, mul_last;
   logic [WIDTH-1:0]   mag_a_in, mag_b_in;
   logic [2*WIDTH-1:0] prod_u, mul_full;

`ifdef MDU_DIV_EN
   logic [WIDTH-1:0]   a_q;
   logic               sa_q;
   logic [WIDTH-1:0]   div_quo, div_rem;
   logic               div_ready;
`endif

   // A request is taken only in IDLE with busy low, which also blocks the done cycle.
   always_comb begin
      signed_in = op_is_signed(op);
      accept    = start && !flush && !busy_q && (state_q == ST_IDLE);
      mag_a_in  = (signed_in && a[WIDTH-1]) ? -a : a;
      mag_b_in  = (signed_in && b[WIDTH-1]) ? -b : b;
      prod_u    = {{WIDTH{1'b0}}, mag_a_q} * {{WIDTH{1'b0}}, mag_b_q};
      mul_full  = neg_q ? -prod_u : prod_u;
      mul_last  = (state_q == ST_MUL) && (cnt_q == CW'(MUL_LAT - 1));
   end

`ifdef MDU_DIV_EN
   mdu_divider #(.WIDTH(WIDTH)) u_divider (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (accept && op[1]),
      .flush     (flush),
      .dividend  (mag_a_in),
      .divisor   (mag_b_in),
      .quotient  (div_quo),
      .remainder (div_rem),
      .ready     (div_ready)
   );
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (!op[1]) begin
                  state_d = (MUL_LAT == 1) ? ST_DONE : ST_MUL;
               end else begin
`ifdef MDU_DIV_EN
                  state_d = ST_DIV;
`else
                  state_d = ST_DONE;
`endif
               end
            end
         end
         ST_MUL:  if (mul_last) state_d = ST_DONE;
`ifdef MDU_DIV_EN
         ST_DIV:  if (div_ready) state_d = ST_FIX;
         ST_FIX:  state_d = ST_DONE;
`else
         ST_DIV:  state_d = ST_IDLE;
         ST_FIX:  state_d = ST_IDLE;
`endif
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (flush) begin
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         dz_q     <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         mag_a_q  <= '0;
         mag_b_q  <= '0;
         res_hi_q <= '0;
         res_lo_q <= '0;
         res_dz_q <= 1'b0;
`ifdef MDU_DIV_EN
         a_q      <= '0;
         sa_q     <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         if (flush) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
         end else begin
            if (accept) begin
               busy_q   <= 1'b1;
               cnt_q    <= CW'(1);
               is_div_q <= op[1];
               neg_q    <= signed_in && (a[WIDTH-1] ^ b[WIDTH-1]);
               mag_a_q  <= mag_a_in;
               mag_b_q  <= mag_b_in;
               res_hi_q <= '0;
               res_lo_q <= '0;
               res_dz_q <= 1'b0;
`ifdef MDU_DIV_EN
               a_q      <= a;
               sa_q     <= signed_in && a[WIDTH-1];
`endif
            end else if (done_q) begin
               busy_q <= 1'b0;
            end
            unique case (state_q)
               ST_MUL: begin
                  cnt_q <= cnt_q + CW'(1);
                  if (mul_last) begin
                     {res_hi_q, res_lo_q} <= mul_full;
                  end
               end
`ifdef MDU_DIV_EN
               // Divide by zero reports the untouched dividend as the remainder.
               ST_FIX: begin
                  if (mag_b_q == '0) begin
                     res_lo_q <= '1;
                     res_hi_q <= a_q;
                     res_dz_q <= 1'b1;
                  end else begin
                     res_lo_q <= neg_q ? -div_quo : div_quo;
                     res_hi_q <= sa_q ? -div_rem : div_rem;
                     res_dz_q <= 1'b0;
                  end
               end
`endif
               ST_DONE: begin
                  done_q <= 1'b1;
                  cnt_q  <= '0;
                  dz_q   <= res_dz_q;
                  if ((MUL_LAT == 1) && !is_div_q) begin
                     {hi_q, lo_q} <= mul_full;
                  end else begin
                     hi_q <= res_hi_q;
                     lo_q <= res_lo_q;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign hi       = hi_q;
   assign lo       = lo_q;
   assign div_zero = dz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboarded bench for mul_div_unit: directed corner cases plus random ops
// checked against an arithmetic reference model.
module tb_mul_div_unit;

   localparam int W   = 32;
   localparam int LAT = 5;
`ifdef MDU_DIV_EN
   localparam int DIV_LAT = W + 2;
`else
   localparam int DIV_LAT = 1;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         flush = 1'b0;
   logic [1:0]   op = 2'd0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy, done, div_zero;
   logic [W-1:0] hi, lo;

   int cyc = 0;
   int vectors = 0;
   int miscompares = 0;

   logic [2*W:0] exp_q[$];
   int           t0_q[$];
   int           lat_q[$];
   logic [W-1:0] model_hi = '0;
   logic [W-1:0] model_lo = '0;
   logic         model_dz = 1'b0;

   mul_div_unit #(.WIDTH(W), .MUL_LAT(LAT)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .flush    (flush),
      .busy     (busy),
      .done     (done),
      .hi       (hi),
      .lo       (lo),
      .div_zero (div_zero)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [2*W:0] model(input logic [1:0] o, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
      longint       sx, sy, q, r;
      logic [2*W-1:0] p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      case (o)
         2'd0: begin
            q = sx * sy;
            p = q;
            return {p, 1'b0};
         end
         2'd1: begin
            p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
            return {p, 1'b0};
         end
         default: begin
`ifdef MDU_DIV_EN
            if (y == '0) return {x, {W{1'b1}}, 1'b1};
            if (o == 2'd3) return {x % y, x / y, 1'b0};
            q = sx / sy;
            r = sx % sy;
            p = {r[W-1:0], q[W-1:0]};
            return {p, 1'b0};
`else
            r = sx + sy;
            return '0;
`endif
         end
      endcase
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   // ---------------- driver ----------------
   task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit track);
      int           guard;
      logic [2*W:0] m;
      guard = 0;
      @(negedge clk);
      while (busy !== 1'b0 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (busy !== 1'b0) begin
         chk("issue_wait_busy", 64'(busy), 64'd0);
         return;
      end
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      if (track) begin
         m = model(o, x, y);
         exp_q.push_back(m);
         t0_q.push_back(cyc + 1);
         lat_q.push_back(o[1] ? DIV_LAT : LAT);
         {model_hi, model_lo, model_dz} = m;
      end
      @(negedge clk);
      // operands scrambled while busy must not affect the result
      start = 1'b0;
      op    = 2'($urandom);
      a     = $urandom;
      b     = $urandom;
   endtask

   task automatic drain();
      int g;
      g = 0;
      while ((exp_q.size() != 0 || busy !== 1'b0) && g < 300) begin
         @(negedge clk);
         g++;
      end
      if (exp_q.size() != 0) begin
         chk("drain_pending", 64'(exp_q.size()), 64'd0);
         exp_q.delete();
         t0_q.delete();
         lat_q.delete();
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(posedge clk) begin : monitor
      logic [2*W:0] e;
      int           t, l;
      #1;
      if (rst_n === 1'b1 && done === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("done_with_empty_queue", 64'(done), 64'd0);
         end else begin
            e = exp_q.pop_front();
            t = t0_q.pop_front();
            l = lat_q.pop_front();
            chk("hi", 64'(hi), 64'(e[2*W:W+1]));
            chk("lo", 64'(lo), 64'(e[W:1]));
            chk("div_zero", 64'(div_zero), 64'(e[0]));
            chk("latency", 64'(cyc - t), 64'(l));
            chk("busy_at_done", 64'(busy), 64'd1);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [1:0]   ro;
      logic [W-1:0] rx, ry;

      repeat (3) @(negedge clk);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_hi", 64'(hi), 64'd0);
      chk("reset_lo", 64'(lo), 64'd0);
      chk("reset_div_zero", 64'(div_zero), 64'd0);
      rst_n = 1'b1;

      issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      issue(2'd0, -32'sd3, 32'd7, 1'b1);
      issue(2'd2, -32'sd7, 32'd2, 1'b1);
      issue(2'd3, 32'd100, 32'd7, 1'b1);
      issue(2'd3, 32'd5, 32'd0, 1'b1);
      issue(2'd1, 32'd2, 32'd3, 1'b1);
      issue(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b1);
      issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      issue(2'd2, 32'd9, 32'hFFFF_FFFD, 1'b1);
      drain();

      // flush mid-operation: no done, outputs hold
`ifdef MDU_DIV_EN
      issue(2'd2, 32'd1000, 32'd7, 1'b0);
      repeat (9) @(negedge clk);
`else
      issue(2'd1, 32'd1000, 32'd7, 1'b0);
`endif
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("busy_after_flush", 64'(busy), 64'd0);
      chk("hi_hold_flush", 64'(hi), 64'(model_hi));
      chk("lo_hold_flush", 64'(lo), 64'(model_lo));
      chk("dz_hold_flush", 64'(div_zero), 64'(model_dz));
      repeat (40) @(negedge clk);
      issue(2'd1, 32'd12345, 32'd678, 1'b1);
      drain();

      // start together with flush is dropped
      @(negedge clk);
      start = 1'b1;
      flush = 1'b1;
      op    = 2'd1;
      a     = 32'd9;
      b     = 32'd9;
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      chk("busy_start_flush", 64'(busy), 64'd0);
      repeat (10) @(negedge clk);

      // start while busy is ignored
      issue(2'd0, 32'd123, -32'sd5, 1'b1);
      start = 1'b1;
      op    = 2'd3;
      a     = 32'd77;
      b     = 32'd0;
      @(negedge clk);
      start = 1'b0;
      drain();
      repeat (5) @(negedge clk);

      for (int i = 0; i < 40; i++) begin
         ro = 2'($urandom_range(0, 3));
         rx = $urandom;
         ry = $urandom;
         if ($urandom_range(0, 3) == 0) ry = $urandom_range(1, 15);
         if ($urandom_range(0, 7) == 0) ry = '0;
         if ($urandom_range(0, 7) == 0) rx = 32'h8000_0000;
         issue(ro, rx, ry, 1'b1);
      end
      drain();

      // reset mid-multiply loses the operation
      issue(2'd1, 32'd7, 32'd9, 1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_hi", 64'(hi), 64'd0);
      chk("rst_lo", 64'(lo), 64'd0);
      chk("rst_div_zero", 64'(div_zero), 64'd0);
      exp_q.delete();
      t0_q.delete();
      lat_q.delete();
      model_hi = '0;
      model_lo = '0;
      model_dz = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      issue(2'd1, 32'd6, 32'd7, 1'b1);
      drain();
      repeat (5) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
